// File: rtl/ide_autoconfig_pkg.sv
// Shared types and constants for the Zorro II IDE AutoConfig controller.
package ide_autoconfig_pkg;

    typedef enum logic [1:0] {
        UNCFG      = 2'd0,
        ACTIVE     = 2'd1,
        CONFIGURED = 2'd2,
        SHUTUP     = 2'd3
    } state_t;

    localparam logic [7:0] ER_TYPE    = 8'h00;
    localparam logic [7:0] ER_SIZE    = 8'h02;
    localparam logic [7:0] ER_PROD_HI = 8'h04;
    localparam logic [7:0] ER_PROD_LO = 8'h06;
    localparam logic [7:0] ER_FLAGS   = 8'h08;
    localparam logic [7:0] ER_BASE_HI = 8'h48;
    localparam logic [7:0] ER_BASE_LO = 8'h4A;
    localparam logic [7:0] ER_SHUTUP  = 8'h4C;

    localparam logic [3:0] Z2_TYPE_NOMEM  = 4'hC;
    localparam logic [3:0] Z2_TYPE_ROMVEC = 4'hD;
    localparam logic [3:0] Z2_SIZE_128K   = 4'h2;

    function automatic logic [3:0] nib16(input logic [15:0] v, input int unsigned idx);
        return v[idx*4 +: 4];
    endfunction

endpackage

// File: rtl/ide_autoconfig_rom.sv
// Combinational AutoConfig offset-to-nibble lookup, including the inversion rule.
// Optional diag ROM vector: define IDE_AUTOCONFIG_ROMVEC_EN.
module ide_autoconfig_rom
    import ide_autoconfig_pkg::*;
#(
    parameter logic [15:0] MANUFACTURER_ID = 16'h07DB,
    parameter logic [7:0]  PRODUCT_ID      = 8'h05,
    parameter logic [31:0] SERIAL          = 32'h00000001,
    parameter logic [15:0] ROM_OFFSET      = 16'h0000
) (
    input  logic [7:0] off_i,
    output logic [3:0] nib_o
);

    logic [3:0] raw;
    logic       invert;

`ifndef IDE_AUTOCONFIG_ROMVEC_EN
    logic rom_offset_unused;
    assign rom_offset_unused = ^ROM_OFFSET;
`endif

    always_comb begin
        raw = '0;
        case (off_i)
`ifdef IDE_AUTOCONFIG_ROMVEC_EN
            ER_TYPE:    raw = Z2_TYPE_ROMVEC;
            8'h28:      raw = nib16(ROM_OFFSET, 3);
            8'h2A:      raw = nib16(ROM_OFFSET, 2);
            8'h2C:      raw = nib16(ROM_OFFSET, 1);
            8'h2E:      raw = nib16(ROM_OFFSET, 0);
`else
            ER_TYPE:    raw = Z2_TYPE_NOMEM;
`endif
            ER_SIZE:    raw = Z2_SIZE_128K;
            ER_PROD_HI: raw = PRODUCT_ID[7:4];
            ER_PROD_LO: raw = PRODUCT_ID[3:0];
            ER_FLAGS:   raw = 4'h0;
            8'h10:      raw = nib16(MANUFACTURER_ID, 3);
            8'h12:      raw = nib16(MANUFACTURER_ID, 2);
            8'h14:      raw = nib16(MANUFACTURER_ID, 1);
            8'h16:      raw = nib16(MANUFACTURER_ID, 0);
            8'h18:      raw = SERIAL[31:28];
            8'h1A:      raw = SERIAL[27:24];
            8'h1C:      raw = SERIAL[23:20];
            8'h1E:      raw = SERIAL[19:16];
            8'h20:      raw = SERIAL[15:12];
            8'h22:      raw = SERIAL[11:8];
            8'h24:      raw = SERIAL[7:4];
            8'h26:      raw = SERIAL[3:0];
            default:    raw = '0;
        endcase
    end

    // Only the type/size nibbles and the $40-$7E control window read true.
    assign invert = !((off_i == ER_TYPE) || (off_i == ER_SIZE) || (off_i[7:6] == 2'b01));
    assign nib_o  = invert ? ~raw : raw;

endmodule

// File: rtl/ide_autoconfig.sv
// Zorro II AutoConfig controller for the IDE card: config space, base latch, chain.
// Optional diag ROM vector (see ide_autoconfig_rom): define IDE_AUTOCONFIG_ROMVEC_EN.
module ide_autoconfig
    import ide_autoconfig_pkg::*;
#(
    parameter logic [15:0] MANUFACTURER_ID = 16'h07DB,
    parameter logic [7:0]  PRODUCT_ID      = 8'h05,
    parameter logic [31:0] SERIAL          = 32'h00000001,
    parameter logic [15:0] ROM_OFFSET      = 16'h0000
) (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic [23:1] ADDR,
    input  logic        AS_n,
    input  logic        UDS_n,
    input  logic        RW,
    input  logic [3:0]  DATA_IN,
    input  logic        CFGIN_n,
    output logic [3:0]  DATA_OUT,
    output logic        data_oe,
    output logic        DTACK_n,
    output logic        CFGOUT_n,
    output logic        ide_access
);

    state_t     state_q, state_d;
    logic [7:0] base_q, base_d;
    logic [3:0] lo_nib_q, lo_nib_d;
    logic [1:0] as_q, as_d;
    logic       dtack_q, dtack_d;

    logic       cfg_hit;
    logic       wr_pulse;
    logic [7:0] off;
    logic [3:0] rom_nib;
    logic       addr_unused;

    assign addr_unused = ^ADDR[15:8];

    assign cfg_hit  = (state_q == ACTIVE) && !AS_n && (ADDR[23:16] == 8'hE8);
    assign wr_pulse = !AS_n && !as_q[0] && as_q[1] && !RW && !UDS_n;
    assign off      = {ADDR[7:1], 1'b0};

    ide_autoconfig_rom #(
        .MANUFACTURER_ID (MANUFACTURER_ID),
        .PRODUCT_ID      (PRODUCT_ID),
        .SERIAL          (SERIAL),
        .ROM_OFFSET      (ROM_OFFSET)
    ) u_rom (
        .off_i (off),
        .nib_o (rom_nib)
    );

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q  <= UNCFG;
            base_q   <= '0;
            lo_nib_q <= '0;
            as_q     <= '1;
            dtack_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            lo_nib_q <= lo_nib_d;
            as_q     <= as_d;
            dtack_q  <= dtack_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        lo_nib_d = lo_nib_q;
        as_d     = AS_n ? 2'b11 : {as_q[0], 1'b0};
        dtack_d  = dtack_q;

        if (AS_n)
            dtack_d = 1'b1;
        else if (cfg_hit && !as_q[0])
            dtack_d = 1'b0;

        case (state_q)
            UNCFG: begin
                if (!CFGIN_n)
                    state_d = ACTIVE;
            end
            ACTIVE: begin
                // Losing CFGIN_n takes priority over a write landing on the same edge.
                if (CFGIN_n) begin
                    state_d = UNCFG;
                end else if (wr_pulse && cfg_hit) begin
                    case (off)
                        ER_BASE_LO: lo_nib_d = DATA_IN;
                        ER_BASE_HI: begin
                            base_d  = {DATA_IN, lo_nib_q};
                            state_d = CONFIGURED;
                        end
                        ER_SHUTUP:  state_d = SHUTUP;
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    assign data_oe    = cfg_hit && RW;
    assign DATA_OUT   = data_oe ? rom_nib : 4'hF;
    assign DTACK_n    = dtack_q;
    assign CFGOUT_n   = !((state_q == CONFIGURED) || (state_q == SHUTUP));
    assign ide_access = (state_q == CONFIGURED) && !AS_n && (ADDR[23:17] == base_q[7:1]);

endmodule

// File: tb/tb_ide_autoconfig.sv
// Scoreboard bench for ide_autoconfig: stimulus queues expectations, monitor checks on negedge.
module tb_ide_autoconfig;

    logic        CLK = 1'b0;
    logic        RESET_n;
    logic [23:1] ADDR;
    logic        AS_n, UDS_n, RW;
    logic [3:0]  DATA_IN;
    logic        CFGIN_n;
    logic [3:0]  DATA_OUT;
    logic        data_oe, DTACK_n, CFGOUT_n, ide_access;

    always #5 CLK = ~CLK;

    ide_autoconfig dut (
        .CLK        (CLK),
        .RESET_n    (RESET_n),
        .ADDR       (ADDR),
        .AS_n       (AS_n),
        .UDS_n      (UDS_n),
        .RW         (RW),
        .DATA_IN    (DATA_IN),
        .CFGIN_n    (CFGIN_n),
        .DATA_OUT   (DATA_OUT),
        .data_oe    (data_oe),
        .DTACK_n    (DTACK_n),
        .CFGOUT_n   (CFGOUT_n),
        .ide_access (ide_access)
    );

    localparam logic [4:0] M_DT  = 5'b00001;
    localparam logic [4:0] M_OE  = 5'b00010;
    localparam logic [4:0] M_DO  = 5'b00100;
    localparam logic [4:0] M_CO  = 5'b01000;
    localparam logic [4:0] M_IDE = 5'b10000;
    localparam logic [4:0] M_BUS = 5'b00111;
    localparam logic [4:0] M_ALL = 5'b11111;

`ifdef IDE_AUTOCONFIG_ROMVEC_EN
    localparam logic [3:0] TYPE_NIB = 4'hD;
`else
    localparam logic [3:0] TYPE_NIB = 4'hC;
`endif

    typedef struct {
        string      name;
        logic [4:0] mask;
        logic       dt;
        logic       oe;
        logic [3:0] dout;
        logic       co;
        logic       ide;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic push(input string nm, input logic [4:0] m, input logic dt, input logic oe,
                        input logic [3:0] d, input logic co, input logic id);
        exp_t e;
        e.name = nm; e.mask = m; e.dt = dt; e.oe = oe; e.dout = d; e.co = co; e.ide = id;
        sb.push_back(e);
    endtask

    task automatic chk(input string nm, input string f, input logic [3:0] act, input logic [3:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s %s: got %h expected %h (t=%0t)", nm, f, act, req, $time);
        end
    endtask

    // Monitor: every queued expectation is checked at the next falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.mask[0]) chk(e.name, "DTACK_n",    {3'b0, DTACK_n},    {3'b0, e.dt});
                if (e.mask[1]) chk(e.name, "data_oe",    {3'b0, data_oe},    {3'b0, e.oe});
                if (e.mask[2]) chk(e.name, "DATA_OUT",   DATA_OUT,           e.dout);
                if (e.mask[3]) chk(e.name, "CFGOUT_n",   {3'b0, CFGOUT_n},   {3'b0, e.co});
                if (e.mask[4]) chk(e.name, "ide_access", {3'b0, ide_access}, {3'b0, e.ide});
            end
        end
    end

    task automatic idle_bus();
        AS_n = 1'b1; UDS_n = 1'b1; RW = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        idle_bus();
        RESET_n = 1'b0;
        push("reset", M_ALL, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0);
        @(posedge CLK); #1;
        RESET_n = 1'b1;
    endtask

    // Config read: DTACK must still be high one edge in, low at the second edge.
    task automatic cfg_read(input logic [23:0] a, input logic [3:0] nib, input bit responds);
        string nm;
        nm = $sformatf("rd %06h", a);
        @(posedge CLK); #1;
        ADDR = a[23:1]; RW = 1'b1; UDS_n = 1'b0; AS_n = 1'b0;
        @(posedge CLK); #1;
        if (responds) push({nm, " e1"}, M_BUS, 1'b1, 1'b1, nib, 1'b0, 1'b0);
        else          push({nm, " e1"}, M_BUS, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0);
        @(posedge CLK); #1;
        if (responds) push({nm, " e2"}, M_BUS, 1'b0, 1'b1, nib, 1'b0, 1'b0);
        else          push({nm, " e2"}, M_BUS, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0);
        @(posedge CLK); #1;
        idle_bus();
        @(posedge CLK); #1;
        push({nm, " end"}, M_BUS, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0);
    endtask

    // Config write held for 'hold' edges; DATA_IN is scrambled after the sampling edge.
    task automatic cfg_write(input logic [23:0] a, input logic [3:0] d, input int hold);
        @(posedge CLK); #1;
        ADDR = a[23:1]; RW = 1'b0; UDS_n = 1'b0; DATA_IN = d; AS_n = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK); #1;
            if (i >= 1) DATA_IN = d ^ 4'(i + 1);
        end
        idle_bus();
        @(posedge CLK); #1;
    endtask

    task automatic bus_access(input logic [23:0] a, input logic exp_ide);
        string nm;
        nm = $sformatf("acc %06h", a);
        @(posedge CLK); #1;
        ADDR = a[23:1]; RW = 1'b1; UDS_n = 1'b0; AS_n = 1'b0;
        push(nm, M_IDE | M_OE, 1'b1, 1'b0, 4'hF, 1'b0, exp_ide);
        @(posedge CLK); #1;
        idle_bus();
        push({nm, " as_hi"}, M_IDE, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0);
        @(posedge CLK); #1;
    endtask

    task automatic expect_cfgout(input string nm, input logic co);
        push(nm, M_CO, 1'b1, 1'b0, 4'hF, co, 1'b0);
        @(posedge CLK); #1;
    endtask

    logic [23:0] rd_addr [16] = '{24'hE80000, 24'hE80002, 24'hE80004, 24'hE80006,
                                  24'hE80008, 24'hE80010, 24'hE80012, 24'hE80014,
                                  24'hE80016, 24'hE80018, 24'hE80026, 24'hE80028,
                                  24'hE80040, 24'hE8007E, 24'hE80080, 24'hE800FE};
    logic [3:0]  rd_nib  [16] = '{TYPE_NIB, 4'h2, 4'hF, 4'hA,
                                  4'hF,     4'hF, 4'h8, 4'h2,
                                  4'h4,     4'hF, 4'hE, 4'hF,
                                  4'h0,     4'h0, 4'hF, 4'hF};

    initial begin
        RESET_n = 1'b0; ADDR = '0; DATA_IN = '0; CFGIN_n = 1'b1;
        idle_bus();
        repeat (2) @(posedge CLK);
        #1 push("reset hold", M_ALL, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0);
        @(posedge CLK); #1 RESET_n = 1'b1;

        // Unconfigured chain: no response at all
        cfg_read(24'hE80000, 4'hF, 1'b0);
        expect_cfgout("uncfg cfgout", 1'b1);

        // Chain enabled: nibble table
        CFGIN_n = 1'b0;
        @(posedge CLK); #1;
        for (int i = 0; i < 16; i++) cfg_read(rd_addr[i], rd_nib[i], 1'b1);
        cfg_read(24'hE90000, 4'hF, 1'b0);

        // CFGIN_n rising on the write-pulse edge cancels the shut-up
        @(posedge CLK); #1;
        ADDR = 23'(24'hE8004C >> 1); RW = 1'b0; UDS_n = 1'b0; AS_n = 1'b0;
        @(posedge CLK); #1 CFGIN_n = 1'b1;
        @(posedge CLK); #1 idle_bus();
        expect_cfgout("cfgin race cfgout", 1'b1);
        cfg_read(24'hE80000, 4'hF, 1'b0);
        CFGIN_n = 1'b0;
        @(posedge CLK); #1;
        cfg_read(24'hE80000, TYPE_NIB, 1'b1);

        // Assign base $EA
        cfg_write(24'hE8004A, 4'hA, 3);
        expect_cfgout("pre-commit cfgout", 1'b1);
        cfg_write(24'hE80048, 4'hE, 3);
        expect_cfgout("configured cfgout", 1'b0);
        bus_access(24'hEA0000, 1'b1);
        bus_access(24'hEB0000, 1'b1);
        bus_access(24'hEC0000, 1'b0);
        bus_access(24'hE90000, 1'b0);
        cfg_read(24'hE80000, 4'hF, 1'b0);
        cfg_write(24'hE80048, 4'h2, 3);
        bus_access(24'hEA0000, 1'b1);
        bus_access(24'hE20000, 1'b0);

        // Shut up
        do_reset();
        CFGIN_n = 1'b0;
        @(posedge CLK); #1;
        cfg_write(24'hE8004C, 4'h0, 3);
        expect_cfgout("shutup cfgout", 1'b0);
        bus_access(24'hEA0000, 1'b0);
        bus_access(24'h000000, 1'b0);
        cfg_read(24'hE80000, 4'hF, 1'b0);

        // Long write, no prior $4A: base $60 from the first pulse only
        do_reset();
        @(posedge CLK); #1;
        cfg_write(24'hE80048, 4'h6, 6);
        expect_cfgout("long write cfgout", 1'b0);
        bus_access(24'h600000, 1'b1);
        bus_access(24'h620000, 1'b0);
        bus_access(24'h400000, 1'b0);
        bus_access(24'h000000, 1'b0);

        // Asynchronous reset in the middle of an IDE access
        @(posedge CLK); #1;
        ADDR = 23'(24'h600000 >> 1); RW = 1'b1; UDS_n = 1'b0; AS_n = 1'b0;
        push("pre-reset acc", M_IDE, 1'b1, 1'b0, 4'hF, 1'b0, 1'b1);
        @(posedge CLK); #2;
        RESET_n = 1'b0;
        push("mid-cycle reset", M_ALL, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0);
        @(posedge CLK); #1;
        idle_bus();
        RESET_n = 1'b1;
        @(posedge CLK); #1;
        cfg_read(24'hE80000, TYPE_NIB, 1'b1);

        repeat (3) @(posedge CLK);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expectations expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
